// File: rtl/letc_core_imss_ifetch_responder.sv
// IMSS instruction-fetch responder: serves fetch requests from a single-entry
// line buffer and refills it over a burst fill bus on a miss.
//   clk, rst_n              core clock, async active-low reset
//   req_valid/req_addr/req_ready    fetch 1 request handshake
//   flush, invalidate       pipeline flush, line-buffer invalidate (fence.i)
//   rsp_valid/rsp_data      instruction word to fetch 2
//   fill_req_*              line-aligned fill request to memory
//   fill_rsp_valid/data     fill beats, ascending word order
module letc_core_imss_ifetch_responder #(
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  input  logic              invalidate,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              fill_req_valid,
  input  logic              fill_req_ready,
  output logic [ADDR_W-1:0] fill_req_addr,
  input  logic              fill_rsp_valid,
  input  logic [31:0]       fill_rsp_data
);

  localparam int unsigned IDX_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam int unsigned TAG_W = ADDR_W - OFF_W;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT} state_e;

  state_e            state_q, state_d;
  logic              line_valid_q, line_valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       data_q [LINE_WORDS];
  logic [31:0]       data_d [LINE_WORDS];
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              inval_pending_q, inval_pending_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              fill_req_valid_q, fill_req_valid_d;
  logic [ADDR_W-1:0] fill_req_addr_q, fill_req_addr_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  cap_idx;
  logic              accept;
  logic              hit;
  logic              unused_byte_offset;

  assign req_tag            = req_addr[ADDR_W-1:OFF_W];
  assign req_idx            = req_addr[OFF_W-1:2];
  assign cap_idx            = addr_q[OFF_W-1:2];
  assign req_ready          = (state_q == IDLE) && !flush;
  assign accept             = req_valid && req_ready;
  assign hit                = line_valid_q && (tag_q == req_tag) && !invalidate;
  assign unused_byte_offset = ^req_addr[1:0];

  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign fill_req_valid = fill_req_valid_q;
  assign fill_req_addr  = fill_req_addr_q;

  always_comb begin
    state_d          = state_q;
    line_valid_d     = line_valid_q;
    tag_d            = tag_q;
    data_d           = data_q;
    addr_d           = addr_q;
    cnt_d            = cnt_q;
    abort_d          = abort_q;
    inval_pending_d  = inval_pending_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_data_d       = rsp_data_q;
    fill_req_valid_d = fill_req_valid_q;
    fill_req_addr_d  = fill_req_addr_q;

    if (invalidate) line_valid_d = 1'b0;
    if (flush)      rsp_valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (hit) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data_q[req_idx];
          end else begin
            rsp_valid_d      = 1'b0;
            addr_d           = req_addr[ADDR_W-1:2];
            fill_req_valid_d = 1'b1;
            fill_req_addr_d  = {req_tag, {OFF_W{1'b0}}};
            state_d          = FILL_REQ;
          end
        end
      end
      FILL_REQ: begin
        if (flush)      abort_d         = 1'b1;
        if (invalidate) inval_pending_d = 1'b1;
        if (fill_req_ready) begin
          fill_req_valid_d = 1'b0;
          cnt_d            = '0;
          state_d          = FILL_WAIT;
        end
      end
      FILL_WAIT: begin
        if (flush)      abort_d         = 1'b1;
        if (invalidate) inval_pending_d = 1'b1;
        if (fill_rsp_valid) begin
          data_d[cnt_q] = fill_rsp_data;
          cnt_d         = cnt_q + IDX_W'(1);
          if (cnt_q == LAST_BEAT) begin
            // Same-cycle flush/invalidate on the last beat still take effect.
            tag_d        = addr_q[ADDR_W-1:OFF_W];
            line_valid_d = !(inval_pending_q || invalidate);
            if (!(abort_q || flush)) begin
              rsp_valid_d = 1'b1;
              // The last word is not in data_q yet; forward it from the bus.
              rsp_data_d  = (cap_idx == LAST_BEAT) ? fill_rsp_data : data_q[cap_idx];
            end
            abort_d         = 1'b0;
            inval_pending_d = 1'b0;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      line_valid_q     <= 1'b0;
      tag_q            <= '0;
      for (int unsigned i = 0; i < LINE_WORDS; i++) data_q[i] <= '0;
      addr_q           <= '0;
      cnt_q            <= '0;
      abort_q          <= 1'b0;
      inval_pending_q  <= 1'b0;
      rsp_valid_q      <= 1'b0;
      rsp_data_q       <= '0;
      fill_req_valid_q <= 1'b0;
      fill_req_addr_q  <= '0;
    end else begin
      state_q          <= state_d;
      line_valid_q     <= line_valid_d;
      tag_q            <= tag_d;
      data_q           <= data_d;
      addr_q           <= addr_d;
      cnt_q            <= cnt_d;
      abort_q          <= abort_d;
      inval_pending_q  <= inval_pending_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_data_q       <= rsp_data_d;
      fill_req_valid_q <= fill_req_valid_d;
      fill_req_addr_q  <= fill_req_addr_d;
    end
  end

`ifndef SYNTHESIS
  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({req_ready, rsp_valid, fill_req_valid}));
  a_fill_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    fill_req_valid && !fill_req_ready |=> fill_req_valid && $stable(fill_req_addr));
  a_rsp_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |-> state_q == IDLE);
`endif

endmodule

// File: doc/letc_core_imss_ifetch_responder.md
Name: letc_core_imss_ifetch_responder

Overview:
- Instruction-side memory subsystem responder: the IMSS end of the fetch interface.
- Accepts fetch requests from fetch 1 and returns the instruction word to fetch 2 on rsp_valid/rsp_data.
- Backed by a single-entry line buffer; misses are refilled over a burst fill bus from the memory system.
- Sits between the core fetch stages and the memory system.

Parameters:
- LINE_WORDS, 4, 32-bit words per line; power of two, >= 2.
- ADDR_W, 32, physical address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  fetch request from fetch 1
- req_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- flush  in  1  discard pending/held response (pipeline flush)
- invalidate  in  1  invalidate line buffer (fence.i)
- rsp_valid  out  1  instruction valid to fetch 2
- rsp_data  out  32  instruction word
- fill_req_valid  out  1  line-fill request to memory
- fill_req_ready  in  1  memory accepts fill request
- fill_req_addr  out  ADDR_W  line-aligned fill address
- fill_rsp_valid  in  1  fill data beat valid
- fill_rsp_data  in  32  fill data beat, ascending word order

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, line valid=0, rsp_valid=0, rsp_data=0, fill_req_valid=0, beat counter=0, abort=0, inval_pending=0. req_ready=1 out of reset.
- Storage:
  - tag = addr[ADDR_W-1:log2(LINE_WORDS)+2]
  - line valid bit
  - LINE_WORDS x 32 data array
  - captured request address register
- States and transitions:
  - IDLE: req_ready = !flush.
    - On accept with hit (tag match & valid & !invalidate): next cycle rsp_valid=1, rsp_data = word[addr[log2(LINE_WORDS)+1:2]]. Hit latency is 1 cycle.
    - On accept with miss: rsp_valid=0 next cycle; go to FILL_REQ.
    - rsp_valid/rsp_data hold stable until the next accepted request or flush.
    - Back-to-back hits are accepted every cycle.
  - FILL_REQ: req_ready=0. fill_req_valid=1 with a line-aligned address, held stable until fill_req_ready. On handshake go to FILL_WAIT, counter=0.
  - FILL_WAIT: req_ready=0. Each fill_rsp_valid writes data[counter] and increments the counter. On the last beat (counter==LINE_WORDS-1), install tag; set valid = !inval_pending. Then:
    - if abort: go to IDLE, rsp_valid stays 0, clear abort and inval_pending.
    - else: rsp_valid=1 the next cycle with the requested word (taken from the incoming beat if it is the last word); go to IDLE.
- Flush:
  - Clears rsp_valid the next cycle.
  - In IDLE, a request presented with flush is not accepted.
  - In FILL_REQ/FILL_WAIT, sets abort. The fill still completes all beats; the line is installed but no response is produced.
- Invalidate:
  - Clears line valid the next cycle.
  - Same-cycle request: treated as a miss.
  - During a fill: sets inval_pending, so the installed line ends invalid.
  - Does not affect a response already held.
- Simultaneous flush+invalidate: both effects apply.
- fill_rsp_valid outside FILL_WAIT is ignored.
- Reset mid-fill: immediately returns to IDLE with line invalid. The memory system is reset on the same rst_n, so no stray beats arrive.
- Counter is log2(LINE_WORDS) bits and wraps to 0 after the last beat.
- Assertions (SIMULATION only):
  - control outputs never X after reset;
  - fill_req_addr stable while fill_req_valid & !fill_req_ready;
  - rsp_valid never asserted while state != IDLE.

Test Plan:
- Cold miss, LINE_WORDS=4:
  - Stimulus: req 0x1008; fill_req_ready=1 immediately; beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
  - Response: fill_req_addr=0x1000; rsp_valid=1 with rsp_data=0xA2 one cycle after the last beat; req_ready=0 throughout.
- Hit streaming:
  - Stimulus: after the line is loaded, requests 0x1000, 0x1004, 0x100C on consecutive cycles.
  - Response: rsp_data 0xA0, 0xA1, 0xA3 on the following three cycles; no fill_req_valid.
- Flush during fill:
  - Stimulus: miss 0x2000; flush on the second beat.
  - Response: all 4 beats consumed; rsp_valid stays 0; a subsequent req 0x2004 hits in 1 cycle.
- Invalidate:
  - Stimulus: invalidate during a fill of 0x3000, then req 0x3000.
  - Response: the request misses and a new fill_req to 0x3000 is issued.
  - Stimulus: invalidate in the same cycle as a hit request.
  - Response: treated as a miss.
- Backpressure:
  - Stimulus: fill_req_ready low for 5 cycles.
  - Response: fill_req_valid/addr held stable for 5 cycles; req_ready=0.
- Async reset:
  - Stimulus: rst_n low mid-FILL_WAIT (asynchronous, between clock edges).
  - Response: rsp_valid=0 and fill_req_valid=0 immediately; after release req_ready=1; the next request misses.
